// File: rtl/demux_stream_1to2_if.sv
// demux_stream_1to2_if: handshake bundle for the 1-to-2 stream demux.
//   Input side : din, sel, in_valid (producer -> demux), in_ready (demux -> producer)
//   Output side: dout_n, out_valid_n (demux -> consumer n), out_ready_n (consumer n -> demux)
//   Debug      : xfer_cnt_n, the count of words popped from channel n
// slave is the demux's view of the bundle; master is the producer/consumer view.
interface demux_stream_1to2_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] din;
  logic             sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dout_0;
  logic [WIDTH-1:0] dout_1;
  logic             out_valid_0;
  logic             out_valid_1;
  logic             out_ready_0;
  logic             out_ready_1;
  logic [CNT_W-1:0] xfer_cnt_0;
  logic [CNT_W-1:0] xfer_cnt_1;

  modport slave (
    input  din, sel, in_valid, out_ready_0, out_ready_1,
    output in_ready, dout_0, dout_1, out_valid_0, out_valid_1,
           xfer_cnt_0, xfer_cnt_1
  );

  modport master (
    output din, sel, in_valid, out_ready_0, out_ready_1,
    input  in_ready, dout_0, dout_1, out_valid_0, out_valid_1,
           xfer_cnt_0, xfer_cnt_1
  );
endinterface

// File: rtl/demux_stream_1to2.sv
// demux_stream_1to2: registered 1-to-2 valid/ready demultiplexer.
// Each input word is steered to channel sel (ROUND_ROBIN=0) or to an internal
// alternating pointer (ROUND_ROBIN=1). Each channel has its own 2-entry FIFO,
// so a stalled consumer only blocks words targeted at its own channel.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : demux_stream_1to2_if.slave (input stream, two output streams,
//           per-channel pop counters)

// Per-channel 2-entry FIFO with pop counter. The head register drives dout
// directly, so output is registered (no push-to-output bypass).
module demux_fifo2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             ready_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;

  assign pop = (count_q != 2'd0) && ready_i;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q + CNT_W'(pop);
    // The parent never pushes while full, so push+pop here implies count==1.
    case ({push_i, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = din_i;
        else                 tail_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Leaving one word: tail moves up. Emptying: head keeps its last value.
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: head_d = din_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign full_o  = (count_q == 2'd2);
  assign valid_o = (count_q != 2'd0);
  assign dout_o  = head_q;
  assign cnt_o   = cnt_q;
endmodule

module demux_stream_1to2 #(
  parameter int WIDTH       = 1,
  parameter int ROUND_ROBIN = 0,
  parameter int CNT_W       = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  demux_stream_1to2_if.slave  bus
);
  localparam int NUM_LANES = 2;

  logic                                  rr_ptr_q, rr_ptr_d;
  logic                                  tgt;
  logic                                  in_rdy;
  logic                                  accept;
  logic [NUM_LANES-1:0]                  full;
  logic [NUM_LANES-1:0]                  push;
  logic [NUM_LANES-1:0]                  valid;
  logic [NUM_LANES-1:0]                  rdy;
  logic [NUM_LANES-1:0][WIDTH-1:0]       dout;
  logic [NUM_LANES-1:0][CNT_W-1:0]       cnt;

  // in_ready depends only on the target and the FIFO state, never on
  // out_ready: a full channel refuses even if it pops this same cycle.
  assign tgt    = (ROUND_ROBIN != 0) ? rr_ptr_q : bus.sel;
  assign in_rdy = !full[tgt];
  assign accept = bus.in_valid && in_rdy;

  always_comb begin
    push      = '0;
    push[tgt] = accept;
  end

  // Pointer advances only on an accepted word, so a refused word is retried
  // on the same channel.
  assign rr_ptr_d = rr_ptr_q ^ (accept && (ROUND_ROBIN != 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign rdy = {bus.out_ready_1, bus.out_ready_0};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    demux_fifo2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[l]),
      .din_i   (bus.din),
      .ready_i (rdy[l]),
      .full_o  (full[l]),
      .valid_o (valid[l]),
      .dout_o  (dout[l]),
      .cnt_o   (cnt[l])
    );
  end

  assign bus.in_ready    = in_rdy;
  assign bus.dout_0      = dout[0];
  assign bus.dout_1      = dout[1];
  assign bus.out_valid_0 = valid[0];
  assign bus.out_valid_1 = valid[1];
  assign bus.xfer_cnt_0  = cnt[0];
  assign bus.xfer_cnt_1  = cnt[1];
endmodule

// File: tb/tb_demux_stream_1to2.sv
// tb_demux_stream_1to2: directed bench for demux_stream_1to2.
// Three instances: sel-routed (a), round-robin (r), and 2-bit counters (c).
// Expected words are queued per channel when a push is expected to be accepted;
// a monitor pops and compares whenever a channel hands a word to its consumer.
module tb_demux_stream_1to2;
  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  logic rr_m;                 // model of the round-robin pointer
  logic [7:0] q[6][$];        // 0/1: a ch0/ch1, 2/3: r ch0/ch1, 4/5: c ch0/ch1

  demux_stream_1to2_if #(.WIDTH(8), .CNT_W(8)) ia ();
  demux_stream_1to2_if #(.WIDTH(8), .CNT_W(8)) ir ();
  demux_stream_1to2_if #(.WIDTH(8), .CNT_W(2)) ic ();

  demux_stream_1to2 #(.WIDTH(8), .ROUND_ROBIN(0), .CNT_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  demux_stream_1to2 #(.WIDTH(8), .ROUND_ROBIN(1), .CNT_W(8)) u_r (.clk(clk), .rst_n(rst_n), .bus(ir));
  demux_stream_1to2 #(.WIDTH(8), .ROUND_ROBIN(0), .CNT_W(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic r, input logic [7:0] d);
    logic [7:0] e;
    if (v && r) begin
      chk($sformatf("pop_expected_ch%0d", k), 32'(q[k].size() > 0), 1);
      if (q[k].size() > 0) begin
        e = q[k].pop_front();
        chk($sformatf("dout_ch%0d", k), 32'(d), 32'(e));
      end
    end
  endtask

  // Words leave a FIFO at the edge following a negedge where valid&&ready.
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ia.out_valid_0, ia.out_ready_0, ia.dout_0);
      mon(1, ia.out_valid_1, ia.out_ready_1, ia.dout_1);
      mon(2, ir.out_valid_0, ir.out_ready_0, ir.dout_0);
      mon(3, ir.out_valid_1, ir.out_ready_1, ir.dout_1);
      mon(4, ic.out_valid_0, ic.out_ready_0, ic.dout_0);
      mon(5, ic.out_valid_1, ic.out_ready_1, ic.dout_1);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one word for one cycle on instance u and check in_ready.
  task automatic put(input int u, input logic [7:0] d, input logic s, input logic exp_rdy);
    logic rdy;
    int   k;
    case (u)
      0: begin ia.in_valid = 1'b1; ia.din = d; ia.sel = s; end
      1: begin ir.in_valid = 1'b1; ir.din = d; ir.sel = s; end
      default: begin ic.in_valid = 1'b1; ic.din = d; ic.sel = s; end
    endcase
    @(negedge clk);
    case (u)
      0: rdy = ia.in_ready;
      1: rdy = ir.in_ready;
      default: rdy = ic.in_ready;
    endcase
    chk($sformatf("in_ready_u%0d_%02h", u, d), 32'(rdy), 32'(exp_rdy));
    k = (u == 1) ? 2 + int'(rr_m) : 2 * u + int'(s);
    if (exp_rdy) begin
      q[k].push_back(d);
      if (u == 1) rr_m = !rr_m;
    end
    @(posedge clk); #1;
    ia.in_valid = 1'b0; ir.in_valid = 1'b0; ic.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0; fails = 0; rr_m = 1'b0;
    rst_n = 1'b1;
    ia.din = '0; ia.sel = 1'b0; ia.in_valid = 1'b0; ia.out_ready_0 = 1'b1; ia.out_ready_1 = 1'b1;
    ir.din = '0; ir.sel = 1'b0; ir.in_valid = 1'b0; ir.out_ready_0 = 1'b1; ir.out_ready_1 = 1'b1;
    ic.din = '0; ic.sel = 1'b0; ic.in_valid = 1'b0; ic.out_ready_0 = 1'b1; ic.out_ready_1 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // Reset state
    chk("rst_a_in_ready", 32'(ia.in_ready), 1);
    chk("rst_a_valid0", 32'(ia.out_valid_0), 0);
    chk("rst_a_valid1", 32'(ia.out_valid_1), 0);
    chk("rst_a_dout0", 32'(ia.dout_0), 0);
    chk("rst_a_cnt0", 32'(ia.xfer_cnt_0), 0);
    chk("rst_r_valid0", 32'(ir.out_valid_0), 0);
    chk("rst_c_cnt0", 32'(ic.xfer_cnt_0), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Sel routing, one-cycle latency
    put(0, 8'h11, 1'b0, 1'b1);
    chk("lat_a_valid0", 32'(ia.out_valid_0), 1);
    chk("lat_a_dout0", 32'(ia.dout_0), 32'h11);
    put(0, 8'h22, 1'b1, 1'b1);
    chk("lat_a_valid1", 32'(ia.out_valid_1), 1);
    put(0, 8'h33, 1'b0, 1'b1);
    idle(3);
    chk("sel_cnt0", 32'(ia.xfer_cnt_0), 2);
    chk("sel_cnt1", 32'(ia.xfer_cnt_1), 1);

    // Backpressure isolation
    ia.out_ready_0 = 1'b0;
    put(0, 8'hA1, 1'b0, 1'b1);
    put(0, 8'hA2, 1'b0, 1'b1);
    put(0, 8'hA3, 1'b0, 1'b0);
    put(0, 8'hB1, 1'b1, 1'b1);
    idle(1);
    chk("bp_valid0", 32'(ia.out_valid_0), 1);
    chk("bp_head0", 32'(ia.dout_0), 32'hA1);
    ia.out_ready_0 = 1'b1;
    idle(3);
    chk("bp_cnt0", 32'(ia.xfer_cnt_0), 4);
    chk("bp_valid0_drained", 32'(ia.out_valid_0), 0);

    // Full channel with simultaneous pop
    ia.out_ready_1 = 1'b0;
    put(0, 8'h01, 1'b1, 1'b1);
    put(0, 8'h02, 1'b1, 1'b1);
    ia.out_ready_1 = 1'b1;
    put(0, 8'h03, 1'b1, 1'b0);
    put(0, 8'h03, 1'b1, 1'b1);
    idle(3);
    chk("full_cnt1", 32'(ia.xfer_cnt_1), 5);

    // Asynchronous reset mid-stream with two words buffered on channel 0
    ia.out_ready_0 = 1'b0;
    put(0, 8'h55, 1'b0, 1'b1);
    put(0, 8'h66, 1'b0, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid0", 32'(ia.out_valid_0), 0);
    chk("arst_valid1", 32'(ia.out_valid_1), 0);
    chk("arst_cnt0", 32'(ia.xfer_cnt_0), 0);
    chk("arst_cnt1", 32'(ia.xfer_cnt_1), 0);
    chk("arst_in_ready", 32'(ia.in_ready), 1);
    chk("arst_dout0", 32'(ia.dout_0), 0);
    for (int k = 0; k < 6; k++) q[k].delete();
    rr_m = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    ia.out_ready_0 = 1'b1;
    idle(2);
    chk("arst_no_output", 32'(ia.out_valid_0), 0);

    // Round-robin, sel held at 1; channel 0 stalls so a refusal occurs
    ir.out_ready_0 = 1'b0;
    put(1, 8'h10, 1'b1, 1'b1);
    put(1, 8'h11, 1'b1, 1'b1);
    put(1, 8'h12, 1'b1, 1'b1);
    put(1, 8'h13, 1'b1, 1'b1);
    put(1, 8'h14, 1'b1, 1'b0);
    ir.out_ready_0 = 1'b1;
    put(1, 8'h14, 1'b1, 1'b0);
    put(1, 8'h14, 1'b1, 1'b1);
    put(1, 8'h15, 1'b1, 1'b1);
    idle(3);
    chk("rr_cnt0", 32'(ir.xfer_cnt_0), 3);
    chk("rr_cnt1", 32'(ir.xfer_cnt_1), 3);

    // Counter wrap with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      put(2, 8'(8'h40 + i), 1'b0, 1'b1);
      idle(1);
      chk($sformatf("wrap_cnt0_%0d", i), 32'(ic.xfer_cnt_0), 32'((i + 1) % 4));
      chk($sformatf("wrap_cnt1_%0d", i), 32'(ic.xfer_cnt_1), 0);
    end

    idle(2);
    for (int k = 0; k < 6; k++)
      chk($sformatf("queue_empty_%0d", k), 32'(q[k].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/demux_stream_1to2.md
# demux_stream_1to2

Registered 1-to-2 stream demultiplexer: the receiving-side counterpart of the team's 2:1 mux cells. It takes one valid/ready input stream and steers each word to one of two output streams, chosen either by `sel` or by an internal round-robin pointer. Each output has a 2-entry FIFO, so one stalled consumer never corrupts the other channel. Per-channel transfer counters support bring-up and debug.

## Interface
- `WIDTH`, 1: data width of `din`, `dout_0`, `dout_1`.
- `ROUND_ROBIN`, 0: 0 = route by `sel`; 1 = ignore `sel` and alternate channels starting at 0.
- `CNT_W`, 8: width of each transfer counter.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `din`  in  WIDTH  input data word.
- `sel`  in  1  target channel (0 → `dout_0`, 1 → `dout_1`); used only when `ROUND_ROBIN=0`.
- `in_valid`  in  1  `din`/`sel` valid.
- `in_ready`  out  1  target channel can accept this cycle.
- `dout_0`, `dout_1`  out  WIDTH  head word of each channel FIFO.
- `out_valid_0`, `out_valid_1`  out  1  channel FIFO non-empty.
- `out_ready_0`, `out_ready_1`  in  1  consumer accepts head word.
- `xfer_cnt_0`, `xfer_cnt_1`  out  CNT_W  count of words popped per channel.

## Operation
- Target channel `t`:
  - `ROUND_ROBIN=0`: `t = sel`.
  - `ROUND_ROBIN=1`: `t = rr_ptr`.
- `in_ready = !full[t]`, combinational from `sel` (or `rr_ptr`) and FIFO state. It does not depend on `in_valid` or on the same-cycle pop.
- Push: when `in_valid && in_ready`, `din` is written to FIFO `t`. Words are never duplicated and never dropped. The other channel is untouched.
- `rr_ptr` toggles only on an accepted push. A refused cycle (`in_valid && !in_ready`) leaves it unchanged, so the producer must hold `din` and retry on the same channel.
- Each channel FIFO:
  - Depth 2, FIFO order.
  - `out_valid_n = (count_n != 0)`; `dout_n` = head entry.
  - Pop occurs when `out_valid_n && out_ready_n`.
- Simultaneous push and pop on the same channel:
  - Count 1: count stays 1; the new word becomes head after the pop.
  - Count 2: a push is impossible because `in_ready` is 0 when full. A pop-only cycle drops count to 1.
  - Count 0: push only, since there is no valid word to pop. The pushed word is not visible until the next cycle (no bypass).
- `xfer_cnt_n` increments by 1 on each pop of channel n and wraps from 2^CNT_W−1 to 0.
- `dout_n` is undefined-but-stable (holds the last head contents) while `out_valid_n=0`. Benches must check `dout_n` only when valid.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by system):
  - All FIFOs empty.
  - `out_valid_0/1=0`, `dout_0/1=0`, `xfer_cnt_0/1=0`, `rr_ptr=0`.
  - `in_ready=1`.
- Reset mid-operation discards all buffered words immediately, with no clock needed.
- Latency: a word accepted at edge k is presented with `out_valid_n=1` from just after edge k. Minimum 1 cycle input-to-output.
- Throughput:
  - One word/cycle per channel sustained when its consumer holds ready=1.
  - Alternating channels also sustain one word/cycle at the input.
- `in_ready` is combinational from `sel`. Producers must not make `sel` depend on `in_ready`.
- No combinational path from `out_ready_n` to `in_ready`.

## Test plan
- Reset:
  - Stimulus: drive `rst_n=0` mid-stream, with channel 0 holding 2 words.
  - Response: `out_valid_0/1=0`, counters 0, `in_ready=1` asynchronously, before the next clock edge.
- Sel routing (`ROUND_ROBIN=0`, `WIDTH=8`, both ready=1):
  - Stimulus: push 0x11 (sel 0), 0x22 (sel 1), 0x33 (sel 0) on consecutive cycles.
  - Response: `dout_0` shows 0x11 then 0x33; `dout_1` shows 0x22; each one cycle after acceptance; `xfer_cnt_0=2`, `xfer_cnt_1=1`.
- Backpressure isolation:
  - Stimulus: `out_ready_0=0`; push 0xA1, 0xA2 (sel 0), then 0xA3 (sel 0), then 0xB1 (sel 1).
  - Response: `in_ready=0` for 0xA3. 0xB1 is accepted on the next cycle by re-targeting `sel=1`. After `out_ready_0` rises, channel 0 pops 0xA1, then 0xA2, in order; 0xA3 is never written.
- Full with simultaneous pop:
  - Stimulus: channel 1 full (0x01, 0x02); assert `out_ready_1`; hold `in_valid` with `sel=1` and `din=0x03`.
  - Response:
    - Cycle 1: pop 0x01, `in_ready=0`.
    - Cycle 2: `in_ready=1`, 0x03 accepted.
    - Output order: 0x01, 0x02, 0x03.
- Round-robin (`ROUND_ROBIN=1`):
  - Stimulus: push 4 words 0x10–0x13 with `sel` held at 1; `out_ready_0` low for 3 cycles.
  - Response: 0x10 and 0x12 go to channel 0, 0x11 and 0x13 go to channel 1. A refused cycle does not advance `rr_ptr`.
- Counter wrap (`CNT_W=2`):
  - Stimulus: pop 5 words on channel 0.
  - Response: `xfer_cnt_0` sequence 1, 2, 3, 0, 1; `xfer_cnt_1` stays 0.
